// File: rtl/db_req_gen.sv
// Request initiator for the key/value filter DB: folds the key into a hash, issues one DB request, waits for a response or a timeout.
// Optional DB_REQ_STATS_EN adds saturating request/hit/timeout counters.
module db_req_gen #(
  parameter int unsigned HASH_SIZE   = 32,
  parameter int unsigned KEY_SIZE    = 96,
  parameter int unsigned VAL_SIZE    = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [3:0]           pkt_op,
  input  logic [KEY_SIZE-1:0]  pkt_key,
  input  logic [VAL_SIZE-1:0]  pkt_value,
  output logic                 db_valid,
  output logic [3:0]           db_op,
  output logic [HASH_SIZE-1:0] db_hash,
  output logic [KEY_SIZE-1:0]  db_key,
  output logic [VAL_SIZE-1:0]  db_value,
  input  logic                 db_resp_valid,
  input  logic [3:0]           db_resp_flag,
  input  logic [VAL_SIZE-1:0]  db_resp_value,
  output logic                 res_valid,
  output logic                 res_hit,
  output logic [3:0]           res_flag,
  output logic [VAL_SIZE-1:0]  res_value
`ifdef DB_REQ_STATS_EN
  ,
  output logic [31:0]          stat_req,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_timeout
`endif
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = KEY_SIZE / WORD_W;
  localparam int unsigned CNT_W     = 8;
  // The window includes the ISSUE cycle, so WAIT expires one count early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept_c;
  logic               hit_c;
  logic               timeout_c;
  logic [WORD_W-1:0]  hash_c;

  // XOR-fold every 32-bit word of the key.
  always_comb begin
    hash_c = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      hash_c = hash_c ^ pkt_key[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    hit_c     = 1'b0;
    timeout_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pkt_valid) begin
          accept_c  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (db_resp_valid) begin
          hit_c     = 1'b1;
          state_nxt = ST_REPORT;
        end else if (cnt == CNT_LAST) begin
          timeout_c = 1'b1;
          state_nxt = ST_REPORT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pkt_ready <= 1'b1;
      db_valid  <= 1'b0;
      db_op     <= '0;
      db_hash   <= '0;
      db_key    <= '0;
      db_value  <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_flag  <= '0;
      res_value <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pkt_ready <= (state_nxt == ST_IDLE);
      db_valid  <= (state_nxt == ST_ISSUE);
      res_valid <= (state_nxt == ST_REPORT);
      if (accept_c) begin
        db_op    <= pkt_op;
        db_hash  <= HASH_SIZE'(hash_c);
        db_key   <= pkt_key;
        db_value <= pkt_value;
      end
      if (hit_c) begin
        res_hit   <= 1'b1;
        res_flag  <= db_resp_flag;
        res_value <= db_resp_value;
      end else if (timeout_c) begin
        res_hit   <= 1'b0;
        res_flag  <= '0;
        res_value <= '0;
      end
    end
  end

`ifdef DB_REQ_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_req     <= '0;
      stat_hit     <= '0;
      stat_timeout <= '0;
    end else begin
      if (accept_c && (stat_req != '1)) begin
        stat_req <= stat_req + 32'd1;
      end
      if ((state == ST_REPORT) && res_hit && (stat_hit != '1)) begin
        stat_hit <= stat_hit + 32'd1;
      end
      if ((state == ST_REPORT) && !res_hit && (stat_timeout != '1)) begin
        stat_timeout <= stat_timeout + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_db_req_gen.sv
// Randomized self-checking bench for db_req_gen against a transaction-level latency/result model.
// Stats checks compile in when DB_REQ_STATS_EN is defined.
module tb_db_req_gen;

  localparam int unsigned HASH_SIZE   = 32;
  localparam int unsigned KEY_SIZE    = 96;
  localparam int unsigned VAL_SIZE    = 32;
  localparam int unsigned WAIT_CYCLES = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [3:0]           pkt_op;
  logic [KEY_SIZE-1:0]  pkt_key;
  logic [VAL_SIZE-1:0]  pkt_value;
  logic                 db_valid;
  logic [3:0]           db_op;
  logic [HASH_SIZE-1:0] db_hash;
  logic [KEY_SIZE-1:0]  db_key;
  logic [VAL_SIZE-1:0]  db_value;
  logic                 db_resp_valid;
  logic [3:0]           db_resp_flag;
  logic [VAL_SIZE-1:0]  db_resp_value;
  logic                 res_valid;
  logic                 res_hit;
  logic [3:0]           res_flag;
  logic [VAL_SIZE-1:0]  res_value;
`ifdef DB_REQ_STATS_EN
  logic [31:0]          stat_req;
  logic [31:0]          stat_hit;
  logic [31:0]          stat_timeout;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: last reported result and activity counts since reset.
  logic                prev_hit;
  logic [3:0]          prev_flag;
  logic [VAL_SIZE-1:0] prev_value;
  int                  n_req;
  int                  n_hit;
  int                  n_to;

  db_req_gen #(
    .HASH_SIZE(HASH_SIZE),
    .KEY_SIZE(KEY_SIZE),
    .VAL_SIZE(VAL_SIZE),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_op(pkt_op),
    .pkt_key(pkt_key),
    .pkt_value(pkt_value),
    .db_valid(db_valid),
    .db_op(db_op),
    .db_hash(db_hash),
    .db_key(db_key),
    .db_value(db_value),
    .db_resp_valid(db_resp_valid),
    .db_resp_flag(db_resp_flag),
    .db_resp_value(db_resp_value),
    .res_valid(res_valid),
    .res_hit(res_hit),
    .res_flag(res_flag),
    .res_value(res_value)
`ifdef DB_REQ_STATS_EN
    ,
    .stat_req(stat_req),
    .stat_hit(stat_hit),
    .stat_timeout(stat_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_hash(input logic [95:0] key);
    logic [95:0] k;
    k = key;
    return k[95:64] ^ k[63:32] ^ k[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; off = cycle after accept in which the DB pulses a response (0 = never).
  task automatic run_txn(input logic [3:0] op, input logic [95:0] key, input logic [31:0] val,
                         input int off, input logic [3:0] rflag, input logic [31:0] rval,
                         input bit keep);
    bit hit;
    int exp_k;
    hit   = (off >= 2) && (off <= int'(WAIT_CYCLES));
    exp_k = hit ? off + 1 : int'(WAIT_CYCLES) + 1;
    check("idle_ready", pkt_ready, 1'b1);
    pkt_valid = 1'b1;
    pkt_op    = op;
    pkt_key   = key;
    pkt_value = val;
    step();
    n_req++;
    pkt_valid = keep;
    if (!keep) begin
      pkt_op    = 4'($urandom);
      pkt_key   = {$urandom, $urandom, $urandom};
      pkt_value = $urandom;
    end
    for (int k = 1; k <= exp_k; k++) begin
      check("db_valid", db_valid, k == 1);
      check("busy_ready", pkt_ready, 1'b0);
      check("res_valid", res_valid, k == exp_k);
      check("db_op", db_op, op);
      check("db_key", db_key, key);
      check("db_value", db_value, val);
      check("db_hash", db_hash, ref_hash(key));
      if (k < exp_k) begin
        check("res_hit_hold", res_hit, prev_hit);
        check("res_flag_hold", res_flag, prev_flag);
        check("res_value_hold", res_value, prev_value);
      end else begin
        check("res_hit", res_hit, hit);
        check("res_flag", res_flag, hit ? rflag : 4'h0);
        check("res_value", res_value, hit ? rval : 32'h0);
      end
      db_resp_valid = (k == off);
      db_resp_flag  = (k == off) ? rflag : 4'($urandom);
      db_resp_value = (k == off) ? rval : $urandom;
      step();
    end
    db_resp_valid = 1'b0;
    prev_hit   = hit;
    prev_flag  = hit ? rflag : 4'h0;
    prev_value = hit ? rval : 32'h0;
    if (hit) n_hit++;
    else     n_to++;
    check("ready_after", pkt_ready, 1'b1);
    check("res_valid_after", res_valid, 1'b0);
    check("db_valid_after", db_valid, 1'b0);
    check("db_hash_after", db_hash, ref_hash(key));
  endtask

  // Response strobe while idle must not produce a result.
  task automatic idle_stray();
    pkt_valid     = 1'b0;
    db_resp_valid = 1'b1;
    db_resp_flag  = 4'($urandom);
    db_resp_value = $urandom;
    step();
    db_resp_valid = 1'b0;
    check("stray_res_valid", res_valid, 1'b0);
    check("stray_ready", pkt_ready, 1'b1);
    check("stray_res_flag", res_flag, prev_flag);
    check("stray_res_value", res_value, prev_value);
  endtask

  task automatic model_reset();
    prev_hit   = 1'b0;
    prev_flag  = 4'h0;
    prev_value = '0;
    n_req      = 0;
    n_hit      = 0;
    n_to       = 0;
  endtask

`ifdef DB_REQ_STATS_EN
  task automatic check_stats();
    check("stat_req", stat_req, 32'(n_req));
    check("stat_hit", stat_hit, 32'(n_hit));
    check("stat_timeout", stat_timeout, 32'(n_to));
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    pkt_valid     = 1'b0;
    pkt_op        = '0;
    pkt_key       = '0;
    pkt_value     = '0;
    db_resp_valid = 1'b0;
    db_resp_flag  = '0;
    db_resp_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", pkt_ready, 1'b1);
    check("rst_db_valid", db_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_db_hash", db_hash, 32'h0);
    check("rst_res_value", res_value, 32'h0);
    rst_n = 1'b1;
    step();

    // Directed: hash + hit, timeout, window edges.
    run_txn(4'b0000, 96'h00000001_00000002_00000004, 32'h0, 2, 4'h5, 32'hCAFE, 1'b0);
    run_txn(4'b0011, {$urandom, $urandom, $urandom}, 32'h1234_5678, 0, 4'h0, 32'h0, 1'b0);
    idle_stray();
    run_txn(4'b0100, {$urandom, $urandom, $urandom}, $urandom, int'(WAIT_CYCLES), 4'hA, 32'hBEEF, 1'b0);
    run_txn(4'b0001, {$urandom, $urandom, $urandom}, $urandom, int'(WAIT_CYCLES) + 1, 4'h3, 32'h77, 1'b0);
    run_txn(4'b0110, {$urandom, $urandom, $urandom}, $urandom, 1, 4'h9, 32'h99, 1'b0);
    idle_stray();

    // Back-to-back with pkt_valid held high.
    run_txn(4'b0000, {$urandom, $urandom, $urandom}, $urandom, 3, 4'h1, $urandom, 1'b1);
    run_txn(4'b0001, {$urandom, $urandom, $urandom}, $urandom, 0, 4'h2, $urandom, 1'b1);
    run_txn(4'b0010, {$urandom, $urandom, $urandom}, $urandom, 2, 4'hF, $urandom, 1'b0);
    idle_stray();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom), {$urandom, $urandom, $urandom}, $urandom,
              int'($urandom_range(0, WAIT_CYCLES + 1)), 4'($urandom), $urandom,
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_stray();
    end
`ifdef DB_REQ_STATS_EN
    check_stats();
`endif

    // Reset in the middle of WAIT aborts the transaction.
    pkt_valid = 1'b1;
    pkt_op    = 4'b0001;
    pkt_key   = {$urandom, $urandom, $urandom};
    pkt_value = $urandom;
    step();
    pkt_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    model_reset();
    check("midrst_ready", pkt_ready, 1'b1);
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_db_valid", db_valid, 1'b0);
    check("midrst_db_key", db_key, 96'h0);
    check("midrst_res_hit", res_hit, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < int'(WAIT_CYCLES) + 2; c++) begin
      step();
      check("postrst_res_valid", res_valid, 1'b0);
      check("postrst_ready", pkt_ready, 1'b1);
    end

    // Three hits and one timeout after reset.
    run_txn(4'b0000, {$urandom, $urandom, $urandom}, $urandom, 2, 4'h4, $urandom, 1'b0);
    run_txn(4'b0000, {$urandom, $urandom, $urandom}, $urandom, 3, 4'h6, $urandom, 1'b0);
    run_txn(4'b0001, {$urandom, $urandom, $urandom}, $urandom, 0, 4'h7, $urandom, 1'b0);
    run_txn(4'b0010, {$urandom, $urandom, $urandom}, $urandom, int'(WAIT_CYCLES), 4'h8, $urandom, 1'b0);
`ifdef DB_REQ_STATS_EN
    step();
    check_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
